// File: rtl/hist_pkg.sv
// Shared definitions for the histogram statistics block: parameter defaults,
// FSM state encoding, result frame layout and flag bit positions.
// Optional feature macro: HIST_STATS_NONZERO_EN (adds a nonzero-bin count byte).
package hist_pkg;

   localparam int NUM_BINS_DEF = 16;
   localparam int CNT_W_DEF    = 8;

   localparam int SUM_W = 12;
   localparam int IDX_W = 4;
   localparam int NZ_W  = 5;
   localparam logic [SUM_W-1:0] SUM_MAX = 12'hFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_EMIT  = 2'd2
   } state_t;

   // Result byte positions within a frame
   localparam int B_PEAK_IDX = 0;
   localparam int B_PEAK_CNT = 1;
   localparam int B_FLAGS    = 2;
   localparam int B_SUM_LO   = 3;
   localparam int B_NONZERO  = 4;

   localparam int FRAME_LEN_BASE = 4;
   localparam int FRAME_LEN_NZ   = 5;
`ifdef HIST_STATS_NONZERO_EN
   localparam int FRAME_LEN = FRAME_LEN_NZ;
`else
   localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

   // Bit positions inside the flags byte
   localparam int FLAG_DROP    = 7;
   localparam int FLAG_LEN_ERR = 6;
   localparam int FLAG_SAT     = 5;

endpackage

// File: rtl/hist_stats_ser.sv
// Result frame serializer: captures a whole frame on load, presents it one
// byte at a time and advances only on a valid/ready handshake.
module hist_stats_ser
   import hist_pkg::*;
#(
   parameter int FRAME_LEN_P = FRAME_LEN_BASE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [FRAME_LEN_P*8-1:0] frame_bytes,
   input  logic                     res_ready,
   output logic [7:0]               res_data,
   output logic                     res_valid,
   output logic                     res_last,
   output logic                     done
);

   localparam int PTR_W = 3;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_LEN_P - 1);

   logic [FRAME_LEN_P*8-1:0] rest;
   logic [PTR_W-1:0]         ptr;
   logic                     hs;

   assign hs   = res_valid & res_ready;
   assign done = hs & (ptr == PTR_LAST);

   // Byte register, remaining-bytes shift register and pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rest      <= '0;
         ptr       <= '0;
         res_data  <= 8'h00;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
      end else if (load) begin
         rest      <= frame_bytes >> 8;
         ptr       <= '0;
         res_data  <= frame_bytes[7:0];
         res_valid <= 1'b1;
         res_last  <= (PTR_LAST == '0);
      end else if (hs) begin
         if (ptr == PTR_LAST) begin
            ptr       <= '0;
            res_data  <= 8'h00;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
         end else begin
            rest     <= rest >> 8;
            ptr      <= ptr + 1'b1;
            res_data <= rest[7:0];
            res_last <= ((ptr + 1'b1) == PTR_LAST);
         end
      end
   end

endmodule

// File: rtl/hist_stats.sv
// Histogram readout statistics: accumulates sum, peak bin and error flags over
// one readout frame, then emits a result frame through hist_stats_ser.
// Optional feature macro: HIST_STATS_NONZERO_EN (appends nonzero-bin count byte).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accumulators clear, waiting for the first beat of a frame
// ST_ACCUM | frame in progress, beats accumulated
// ST_EMIT  | result frame being sent; incoming beats are dropped
module hist_stats
   import hist_pkg::*;
#(
   parameter int NUM_BINS = NUM_BINS_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] bin_count,
   input  logic             bin_valid,
   input  logic             bin_last,
   output logic             in_ready,
   output logic [7:0]       res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_last
);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_BINS - 1);
   localparam int AW = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;

   state_t state, state_nx;

   logic [IDX_W-1:0] bin_idx, peak_idx, peak_idx_nx;
   logic             idx_full;
   logic [SUM_W-1:0] sum, sum_nx;
   logic [AW-1:0]    sum_wide;
   logic             sat, sat_nx;
   logic [CNT_W-1:0] peak_cnt, peak_cnt_nx;
   logic             len_err, len_err_nx;
   logic             drop;
   logic             accept, load, drop_beat, first, ser_done;
   logic [7:0]       flags;
   logic [FRAME_LEN*8-1:0] frame_bytes;

   assign accept    = bin_valid & in_ready;
   assign load      = accept & bin_last;
   assign drop_beat = bin_valid & (state == ST_EMIT);
   assign first     = (state == ST_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state and in_ready
   always_comb begin
      state_nx = state;
      in_ready = (state != ST_EMIT);
      case (state)
         ST_IDLE:  if (bin_valid) state_nx = bin_last ? ST_EMIT : ST_ACCUM;
         ST_ACCUM: if (bin_valid && bin_last) state_nx = ST_EMIT;
         ST_EMIT:  if (ser_done) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Accumulator values including the beat currently presented
   always_comb begin
      sum_wide = AW'(sum) + AW'(bin_count);
      if (sum_wide > AW'(SUM_MAX)) begin
         sum_nx = SUM_MAX;
         sat_nx = 1'b1;
      end else begin
         sum_nx = sum_wide[SUM_W-1:0];
         sat_nx = sat;
      end
      if (first || (bin_count > peak_cnt)) begin
         peak_cnt_nx = bin_count;
         peak_idx_nx = bin_idx;
      end else begin
         peak_cnt_nx = peak_cnt;
         peak_idx_nx = peak_idx;
      end
      len_err_nx = len_err | idx_full | (bin_last & (bin_idx != IDX_MAX));
   end

   // Accumulators: update per accepted beat, clear once the result is sent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_idx  <= '0;
         idx_full <= 1'b0;
         sum      <= '0;
         sat      <= 1'b0;
         peak_cnt <= '0;
         peak_idx <= '0;
         len_err  <= 1'b0;
      end else if (ser_done) begin
         bin_idx  <= '0;
         idx_full <= 1'b0;
         sum      <= '0;
         sat      <= 1'b0;
         peak_cnt <= '0;
         peak_idx <= '0;
         len_err  <= 1'b0;
      end else if (accept) begin
         sum      <= sum_nx;
         sat      <= sat_nx;
         peak_cnt <= peak_cnt_nx;
         peak_idx <= peak_idx_nx;
         len_err  <= len_err_nx;
         if (bin_idx == IDX_MAX) idx_full <= 1'b1;
         else                    bin_idx  <= bin_idx + 1'b1;
      end
   end

   // DROP: reported in the frame loaded next, so it clears at that load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         drop <= 1'b0;
      else if (load)      drop <= 1'b0;
      else if (drop_beat) drop <= 1'b1;
   end

`ifdef HIST_STATS_NONZERO_EN
   logic [NZ_W-1:0] nz_cnt, nz_cnt_nx;

   assign nz_cnt_nx = ((bin_count != '0) && (nz_cnt != '1)) ? nz_cnt + 1'b1 : nz_cnt;

   // Count of nonzero bins in the current frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        nz_cnt <= '0;
      else if (ser_done) nz_cnt <= '0;
      else if (accept)   nz_cnt <= nz_cnt_nx;
   end
`endif

   // Result frame assembled from the values including the final beat
   always_comb begin
      flags                = 8'h00;
      flags[FLAG_DROP]     = drop;
      flags[FLAG_LEN_ERR]  = len_err_nx;
      flags[FLAG_SAT]      = sat_nx;
      flags[3:0]           = sum_nx[SUM_W-1:8];
      frame_bytes                        = '0;
      frame_bytes[B_PEAK_IDX*8 +: 8]     = {4'b0, peak_idx_nx};
      frame_bytes[B_PEAK_CNT*8 +: 8]     = 8'(peak_cnt_nx);
      frame_bytes[B_FLAGS*8 +: 8]        = flags;
      frame_bytes[B_SUM_LO*8 +: 8]       = sum_nx[7:0];
`ifdef HIST_STATS_NONZERO_EN
      frame_bytes[B_NONZERO*8 +: 8]      = 8'(nz_cnt_nx);
`endif
   end

   hist_stats_ser #(
      .FRAME_LEN_P (FRAME_LEN)
   ) u_ser (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .frame_bytes (frame_bytes),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_valid   (res_valid),
      .res_last    (res_last),
      .done        (ser_done)
   );

endmodule

// File: tb/tb_hist_stats.sv
// Scoreboard bench for hist_stats: stimulus pushes hand-computed result bytes,
// a monitor pops and compares on every output handshake.
module tb_hist_stats;

   logic       clk;
   logic       rst_n;
   logic [7:0] bin_count;
   logic       bin_valid;
   logic       bin_last;
   logic       in_ready;
   logic [7:0] res_data;
   logic       res_valid;
   logic       res_ready;
   logic       res_last;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   exp_t       exp_q[$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] fr [0:19];
   logic       stall_seen;
   logic [7:0] stall_data;

   hist_stats dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin_count (bin_count),
      .bin_valid (bin_valid),
      .bin_last  (bin_last),
      .in_ready  (in_ready),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_last  (res_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: compare each handshaked byte, and check stability while stalled
   initial begin
      stall_seen = 1'b0;
      stall_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_seen = 1'b0;
         end else begin
            if (stall_seen && res_valid) chk("stall_hold", {24'd0, res_data}, {24'd0, stall_data});
            if (res_valid && res_ready) begin
               stall_seen = 1'b0;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_byte actual=0x%0h required=none", res_data);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if (res_data !== e.d || res_last !== e.l) begin
                     failures++;
                     $display("FAIL res_byte actual=0x%0h/last%0b required=0x%0h/last%0b",
                              res_data, res_last, e.d, e.l);
                  end
               end
            end else if (res_valid) begin
               stall_seen = 1'b1;
               stall_data = res_data;
            end else begin
               stall_seen = 1'b0;
            end
         end
      end
   end

   task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] nz);
      exp_q.push_back('{b0, 1'b0});
      exp_q.push_back('{b1, 1'b0});
      exp_q.push_back('{b2, 1'b0});
`ifdef HIST_STATS_NONZERO_EN
      exp_q.push_back('{b3, 1'b0});
      exp_q.push_back('{nz, 1'b1});
`else
      exp_q.push_back('{b3, 1'b1});
      if (nz === 8'hxx) $display("note: unknown nonzero count");
`endif
   endtask

   task automatic set_fr(input logic [7:0] v);
      for (int i = 0; i < 20; i++) fr[i] = v;
   endtask

   task automatic load_a();
      set_fr(8'h00);
      fr[1] = 8'h03; fr[2] = 8'h09; fr[3] = 8'h09; fr[4] = 8'h01;
   endtask

   // Drive n back-to-back beats with bin_last on beat last_pos
   task automatic send_frame(input int n, input int last_pos);
      for (int i = 0; i < n; i++) begin
         bin_count = fr[i];
         bin_valid = 1'b1;
         bin_last  = (i == last_pos);
         @(posedge clk); #1;
      end
      bin_valid = 1'b0;
      bin_last  = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      bin_count = 8'h00;
      bin_valid = 1'b0;
      bin_last  = 1'b0;
      res_ready = 1'b1;
      #1;
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_last", {31'd0, res_last}, 32'd0);
      chk("rst_data", {24'd0, res_data}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame, first byte one cycle after bin_last
      load_a();
      push_frame(8'h02, 8'h09, 8'h00, 8'h16, 8'h04);
      send_frame(16, 15);
      chk("emit_in_ready", {31'd0, in_ready}, 32'd0);
      chk("latency_valid", {31'd0, res_valid}, 32'd1);
      wait_drain(50);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // All 0xFF: sum 0xFF0, no saturation
      set_fr(8'hFF);
      push_frame(8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h10);
      send_frame(16, 15);
      wait_drain(50);

      // Early bin_last sets LEN_ERR; following correct frame is clean
      set_fr(8'h00);
      fr[0] = 8'h01; fr[1] = 8'h02; fr[2] = 8'h03; fr[3] = 8'h04; fr[4] = 8'h05;
      push_frame(8'h04, 8'h05, 8'h4F & 8'h40, 8'h0F, 8'h05);
      send_frame(5, 4);
      wait_drain(50);
      load_a();
      push_frame(8'h02, 8'h09, 8'h00, 8'h16, 8'h04);
      send_frame(16, 15);
      wait_drain(50);

      // Single-beat frame goes straight to EMIT
      fr[0] = 8'h07;
      push_frame(8'h00, 8'h07, 8'h40, 8'h07, 8'h01);
      send_frame(1, 0);
      chk("single_in_ready", {31'd0, in_ready}, 32'd0);
      wait_drain(50);

      // Stall on B1 for 3 cycles while 2 beats arrive (dropped)
      res_ready = 1'b0;
      load_a();
      push_frame(8'h02, 8'h09, 8'h00, 8'h16, 8'h04);
      send_frame(16, 15);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      bin_valid = 1'b1; bin_count = 8'hAA; bin_last = 1'b1;
      @(posedge clk); #1;
      bin_count = 8'h55; bin_last = 1'b0;
      @(posedge clk); #1;
      bin_valid = 1'b0;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_b1", {24'd0, res_data}, 32'h09);
      @(posedge clk); #1;
      res_ready = 1'b1;
      wait_drain(50);
      push_frame(8'h02, 8'h09, 8'h80, 8'h16, 8'h04);
      send_frame(16, 15);
      wait_drain(50);
      push_frame(8'h02, 8'h09, 8'h00, 8'h16, 8'h04);
      send_frame(16, 15);
      wait_drain(50);

      // Overlength frame: 17 beats of 1, index saturates
      set_fr(8'h01);
      push_frame(8'h00, 8'h01, 8'h40, 8'h11, 8'h11);
      send_frame(17, 16);
      wait_drain(50);

      // Sum saturation: 18 beats of 0xFF
      set_fr(8'hFF);
      push_frame(8'h00, 8'hFF, 8'h6F, 8'hFF, 8'h12);
      send_frame(18, 17);
      wait_drain(50);

      // Reset during EMIT after B1 is taken
      load_a();
      exp_q.push_back('{8'h02, 1'b0});
      exp_q.push_back('{8'h09, 1'b0});
      send_frame(16, 15);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_q", exp_q.size(), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_quiet", {31'd0, res_valid}, 32'd0);
      set_fr(8'hFF);
      push_frame(8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h10);
      send_frame(16, 15);
      wait_drain(50);

      chk("final_q_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hist_stats.md
HIST_STATS -- requirements
Module: hist_stats

Interface
REQ-001 Parameter NUM_BINS, default 16, number of bins per readout frame (power of two, 2..16).
REQ-002 Parameter CNT_W, default 8, width of one bin count.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port bin_count  input  CNT_W  bin count beat from the histogram readout stream.
REQ-006 Port bin_valid  input  1  bin_count carries a beat this cycle.
REQ-007 Port bin_last  input  1  beat is the final bin of the frame; qualified by bin_valid.
REQ-008 Port in_ready  output  1  high when beats are accepted; informational only, upstream has no backpressure.
REQ-009 Port res_data  output  8  result frame byte.
REQ-010 Port res_valid  output  1  res_data valid; held until accepted.
REQ-011 Port res_ready  input  1  downstream accepts the byte when res_valid and res_ready are both high.
REQ-012 Port res_last  output  1  high with the final result byte.

Function
REQ-013 States SHALL be IDLE, ACCUM and EMIT; in_ready SHALL be high in IDLE and ACCUM and low in EMIT.
REQ-014 IDLE -> ACCUM on a valid beat with bin_last low; IDLE -> EMIT on a valid beat with bin_last high (single-beat frame).
REQ-015 Each accepted beat: bin index +1 (starting at 0), sum += bin_count, peak updated only if bin_count > current peak (tie keeps the lowest index).
REQ-016 Sum register SHALL be 12 bits, saturating at 0xFFF.
REQ-017 Peak index SHALL be 4 bits; first beat initialises peak count and index unconditionally, so all-zero frames report index 0 and count 0.
REQ-018 Bin index SHALL saturate at NUM_BINS-1; a beat arriving at saturated index sets LEN_ERR and still accumulates into sum and peak.
REQ-019 bin_last at index != NUM_BINS-1 SHALL set LEN_ERR.
REQ-020 Beats with bin_valid high while in EMIT SHALL be dropped and set DROP for the next frame; bin_last among them SHALL be ignored.
REQ-021 ACCUM -> EMIT on the accepted bin_last beat; first result byte valid the following cycle (latency 1).
REQ-022 Result frame bytes: B0 = {4'b0, peak_idx}; B1 = peak count (low 8 bits); B2 = {DROP, LEN_ERR, SAT, 1'b0, sum[11:8]}; B3 = sum[7:0].
REQ-023 SAT is set when the sum saturated.
REQ-024 res_data/res_valid SHALL be stable while res_valid high and res_ready low; the byte pointer advances only on handshake.
REQ-025 Handshake on the final byte: EMIT -> IDLE, clear accumulators and LEN_ERR/SAT; DROP clears only after being reported.
REQ-026 Dropped beats in the EMIT -> IDLE handshake cycle SHALL still count as dropped.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, res_valid 0, res_last 0, res_data 0x00, in_ready 1, and clear all accumulators and flags.
REQ-028 Reset mid-ACCUM or mid-EMIT SHALL discard the partial frame; no bytes emitted after release until a new frame completes.

Configuration
REQ-029 Macro HIST_STATS_NONZERO_EN defined: append B4 = count of nonzero bins (5 bits, zero-extended); res_last moves to B4.
REQ-030 Macro absent: frame is exactly four bytes and no nonzero-count logic exists.

Structure
REQ-031 Shared package hist_pkg SHALL hold NUM_BINS/CNT_W defaults, state enum, result byte indices, frame length constants and B2 flag bit positions.
REQ-032 Sub-module hist_stats_ser SHALL hold the result byte register, byte pointer and valid/ready handshake; the parent holds the FSM and accumulators.

Verification
REQ-033 Beats 0,3,9,9,1,0..0 (16, last on bin 15), res_ready=1 -> bytes 0x02,0x09,0x00,0x16, res_last on B3.
REQ-034 Sixteen beats of 0xFF -> B0=0x00, B1=0xFF, B2=0x0F, B3=0xF0; no SAT.
REQ-035 bin_last on beat 5 -> B2 bit6 (LEN_ERR) set; next correct frame has it clear.
REQ-036 res_ready low 3 cycles on B1 while 2 beats arrive -> B1 held stable, no loss; next frame B2 bit7 (DROP) set.
REQ-037 rst_n pulsed low during EMIT after B1 -> res_valid 0 immediately; no further bytes until a new full frame.
REQ-038 With HIST_STATS_NONZERO_EN, frame from REQ-033 -> fifth byte 0x04 carrying res_last.
